// File: rtl/rnn_input_feeder_if.sv
// Host-stream and core-side handshake bundle for the RNN input feeder.
// The feeder takes the slave view; the host/core environment takes the master view.
interface rnn_input_feeder_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              ready;
    logic              busy;
    logic              i_en;
    logic [DATA_W-1:0] idata;

    modport master (
        output s_valid, s_data, s_last, busy, i_en,
        input  s_ready, ready, idata
    );

    modport slave (
        input  s_valid, s_data, s_last, busy, i_en,
        output s_ready, ready, idata
    );
endinterface

// File: rtl/rnn_input_feeder.sv
// RNN input feeder: buffers host input vectors in a first-word-fall-through
// FIFO, requests a core start once enough words (or the whole sequence) are
// present, serves the head word on each core i_en, and flushes after the
// core finishes the sequence.
module rnn_input_feeder #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int START_LVL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    rnn_input_feeder_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic [2:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_THR = (AW+1)'(START_LVL);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic              last_seen;
    logic              ready_q;
    logic              underrun_q;

    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              flush;

    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);
    assign flush = (state == DONE);

    // Host acceptance: open in every state except DONE, closed once the
    // sequence tail is buffered, when full, or while reset is held.
    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE, FILL, ARM, RUN: accept = reset && !full && !last_seen;
            default:              accept = 1'b0;
        endcase
    end

    assign push = bus.s_valid && accept;
    assign pop  = bus.i_en && !empty;

    // Sequence control: fill, arm the core, run, then flush.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push) state_nxt = FILL;
            FILL: if ((count >= START_THR) || last_seen) state_nxt = ARM;
            ARM:  if (bus.busy) state_nxt = RUN;
            RUN:  if (!bus.busy) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; ready is registered from the next state so it rises
    // on the arming edge and falls on the edge that samples busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ARM);
        end
    end

    // Tail-of-sequence marker: set by a pushed s_last, cleared when the
    // sequence returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_seen <= 1'b0;
        end else if ((state_nxt == IDLE) && (state != IDLE)) begin
            last_seen <= 1'b0;
        end else if (push && bus.s_last) begin
            last_seen <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; DONE discards whatever the core left unread.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates the read.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= bus.s_data;
        end
    end

    // Sticky flag for a core read attempted against an empty FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun_q <= 1'b0;
        end else if (bus.i_en && empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign bus.idata   = empty ? '0 : mem[rd_ptr];
    assign bus.s_ready = accept;
    assign bus.ready   = ready_q;
    assign level       = count;
    assign underrun    = underrun_q;
    assign state_o     = state;

endmodule
